// File: rtl/fft_pkg.sv
// Shared widths and saturation limits for the complex MAC datapath.
package fft_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_FRAC_W = 8;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_LEN    = 32;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    localparam longint SAT_MAX = sat_max(DEF_ACC_W);
    localparam longint SAT_MIN = sat_min(DEF_ACC_W);

endpackage

// File: rtl/complex_mac_pipe_if.sv
// Operand/result bundle of the complex MAC; master drives samples, slave is the MAC.
interface complex_mac_pipe_if
    import fft_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
);
    logic signed [DATA_W-1:0] a_re;
    logic signed [DATA_W-1:0] a_im;
    logic signed [DATA_W-1:0] b_re;
    logic signed [DATA_W-1:0] b_im;
    logic                     in_valid;
    logic                     sload;
    logic                     conj_b;
    logic signed [ACC_W-1:0]  acc_re;
    logic signed [ACC_W-1:0]  acc_im;
    logic                     out_valid;
    logic                     out_last;
    logic                     ovf;

    modport master (
        output a_re, a_im, b_re, b_im, in_valid, sload, conj_b,
        input  acc_re, acc_im, out_valid, out_last, ovf
    );

    modport slave (
        input  a_re, a_im, b_re, b_im, in_valid, sload, conj_b,
        output acc_re, acc_im, out_valid, out_last, ovf
    );
endinterface

// File: rtl/cmult_pipe.sv
// Input register + full-precision complex product register, optional conj(B).
// Latency 2 cycles, one sample per clock, no backpressure.
module cmult_pipe
    import fft_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     aclr,
    input  logic                     i_vld,
    input  logic                     i_sload,
    input  logic                     i_conj,
    input  logic signed [DATA_W-1:0] i_a_re,
    input  logic signed [DATA_W-1:0] i_a_im,
    input  logic signed [DATA_W-1:0] i_b_re,
    input  logic signed [DATA_W-1:0] i_b_im,
    output logic                     o_vld,
    output logic                     o_sload,
    output logic signed [2*DATA_W:0] o_p_re,
    output logic signed [2*DATA_W:0] o_p_im
);
    localparam int PW = 2 * DATA_W + 1;

    logic                     r_vld1, r_sload1, r_conj1, r_vld2, r_sload2;
    logic signed [DATA_W-1:0] r_a_re, r_a_im, r_b_re, r_b_im;
    logic signed [PW-1:0]     r_p_re, r_p_im;
    logic signed [PW-1:0]     w_rr, w_ii, w_ri, w_ir, w_p_re, w_p_im;

    assign w_rr = PW'(r_a_re) * PW'(r_b_re);
    assign w_ii = PW'(r_a_im) * PW'(r_b_im);
    assign w_ri = PW'(r_a_re) * PW'(r_b_im);
    assign w_ir = PW'(r_a_im) * PW'(r_b_re);

    always_comb begin
        w_p_re = w_rr - w_ii;
        w_p_im = w_ri + w_ir;
        if (r_conj1) begin
            w_p_re = w_rr + w_ii;
            w_p_im = w_ir - w_ri;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_vld1   <= 1'b0;
            r_sload1 <= 1'b0;
            r_conj1  <= 1'b0;
            r_a_re   <= '0;
            r_a_im   <= '0;
            r_b_re   <= '0;
            r_b_im   <= '0;
            r_vld2   <= 1'b0;
            r_sload2 <= 1'b0;
            r_p_re   <= '0;
            r_p_im   <= '0;
        end else begin
            r_vld1   <= i_vld;
            r_sload1 <= i_vld & i_sload;
            r_vld2   <= r_vld1;
            r_sload2 <= r_sload1;
            // Data registers only move with a valid sample to avoid idle toggling.
            if (i_vld) begin
                r_conj1 <= i_conj;
                r_a_re  <= i_a_re;
                r_a_im  <= i_a_im;
                r_b_re  <= i_b_re;
                r_b_im  <= i_b_im;
            end
            if (r_vld1) begin
                r_p_re <= w_p_re;
                r_p_im <= w_p_im;
            end
        end
    end

    assign o_vld   = r_vld2;
    assign o_sload = r_sload2;
    assign o_p_re  = r_p_re;
    assign o_p_im  = r_p_im;
endmodule

// File: rtl/complex_mac_pipe.sv
// Complex multiply-accumulate with round-half-up, saturation, sticky ovf and frame count.
// Latency 3 cycles input to acc, one sample per clock, no backpressure.
module complex_mac_pipe
    import fft_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN    = DEF_LEN
) (
    input  logic               clk,
    input  logic               aclr,
    complex_mac_pipe_if.slave  bus
);
    localparam int PW = 2 * DATA_W + 1;
    localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 2;
    localparam int CW = $clog2(LEN + 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));
    localparam logic signed [SW-1:0]    HI_X    = SW'(ACC_MAX);
    localparam logic signed [SW-1:0]    LO_X    = SW'(ACC_MIN);
    localparam logic signed [SW-1:0]    RND     = SW'(longint'(1) <<< (FRAC_W - 1));

    logic                    w_vld2, w_sload2;
    logic signed [PW-1:0]    w_p_re, w_p_im;
    logic signed [SW-1:0]    w_t_re, w_t_im, w_s_re, w_s_im;
    logic signed [ACC_W-1:0] w_sat_re, w_sat_im;
    logic                    w_clip_re, w_clip_im;
    logic [CW-1:0]           w_cnt_nxt;

    logic signed [ACC_W-1:0] r_acc_re, r_acc_im;
    logic                    r_vld, r_last, r_ovf;
    logic [CW-1:0]           r_cnt;

    cmult_pipe #(.DATA_W(DATA_W)) u_cmult (
        .clk     (clk),
        .aclr    (aclr),
        .i_vld   (bus.in_valid),
        .i_sload (bus.sload),
        .i_conj  (bus.conj_b),
        .i_a_re  (bus.a_re),
        .i_a_im  (bus.a_im),
        .i_b_re  (bus.b_re),
        .i_b_im  (bus.b_im),
        .o_vld   (w_vld2),
        .o_sload (w_sload2),
        .o_p_re  (w_p_re),
        .o_p_im  (w_p_im)
    );

    // Returns {clipped, value}; SW leaves headroom so the compare never wraps.
    function automatic logic [ACC_W:0] sat(input logic signed [SW-1:0] x);
        if (x > HI_X) return {1'b1, ACC_MAX};
        if (x < LO_X) return {1'b1, ACC_MIN};
        return {1'b0, x[ACC_W-1:0]};
    endfunction

    always_comb begin
        w_t_re = (SW'(w_p_re) + RND) >>> FRAC_W;
        w_t_im = (SW'(w_p_im) + RND) >>> FRAC_W;
        w_s_re = w_sload2 ? w_t_re : SW'(r_acc_re) + w_t_re;
        w_s_im = w_sload2 ? w_t_im : SW'(r_acc_im) + w_t_im;
        {w_clip_re, w_sat_re} = sat(w_s_re);
        {w_clip_im, w_sat_im} = sat(w_s_im);
        w_cnt_nxt = (w_sload2 || r_cnt == CW'(LEN)) ? CW'(1) : r_cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_vld    <= 1'b0;
            r_last   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_vld  <= w_vld2;
            r_last <= w_vld2 && (w_cnt_nxt == CW'(LEN));
            if (w_vld2) begin
                r_acc_re <= w_sat_re;
                r_acc_im <= w_sat_im;
                r_cnt    <= w_cnt_nxt;
                r_ovf    <= (w_clip_re | w_clip_im) | (r_ovf & ~w_sload2);
            end
        end
    end

    assign bus.acc_re    = r_acc_re;
    assign bus.acc_im    = r_acc_im;
    assign bus.out_valid = r_vld;
    assign bus.out_last  = r_last;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_complex_mac_pipe.sv
// Directed bench for complex_mac_pipe at default parameters.
module tb_complex_mac_pipe;
    logic clk = 1'b0;
    logic aclr = 1'b1;
    always #5 clk = ~clk;

    complex_mac_pipe_if #(.DATA_W(16), .ACC_W(24)) bus ();

    complex_mac_pipe #(.DATA_W(16), .FRAC_W(8), .ACC_W(24), .LEN(32)) dut (
        .clk  (clk),
        .aclr (aclr),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [2:0] hist = '0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, want);
        end
    endtask

    task automatic chk_acc(input string tag, input int re, input int im);
        chk({tag, ".re"}, bus.acc_re, re);
        chk({tag, ".im"}, bus.acc_im, im);
    endtask

    // One clock: drive a sample, sample outputs 1 time unit after the edge,
    // and check out_valid against the valid bit driven two steps earlier.
    task automatic step(input logic v, input logic sl, input logic cj,
                        input int ar, input int ai, input int br, input int bi);
        bus.in_valid = v;
        bus.sload    = sl;
        bus.conj_b   = cj;
        bus.a_re     = 16'(ar);
        bus.a_im     = 16'(ai);
        bus.b_re     = 16'(br);
        bus.b_im     = 16'(bi);
        @(posedge clk);
        #1;
        hist = {hist[1:0], v};
        chk("out_valid", bus.out_valid, hist[2]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    int sar [4] = '{256, 256, 256, -512};
    int sai [4] = '{0, 256, 256, 0};
    int sbr [4] = '{256, 256, 256, 256};
    int sbi [4] = '{0, -256, -256, 128};
    logic scj [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int gap [3] = '{1, 2, 3};
    int sat_exp [4] = '{4194048, 8388096, 8388607, 8388607};
    logic ovf_exp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        bus.in_valid = 1'b0;
        bus.sload    = 1'b0;
        bus.conj_b   = 1'b0;
        bus.a_re     = '0;
        bus.a_im     = '0;
        bus.b_re     = '0;
        bus.b_im     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_acc("rst", 0, 0);
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.out_last", bus.out_last, 0);
        chk("rst.ovf", bus.ovf, 0);
        aclr = 1'b0;
        hist = '0;

        // A*B: (256+256j)(256-256j) = 131072 -> 512
        step(1'b1, 1'b1, 1'b0, 256, 256, 256, -256);
        idle(2);
        chk_acc("mul", 512, 0);
        chk("mul.ovf", bus.ovf, 0);

        // A*conj(B) -> 131072j -> 512j
        step(1'b1, 1'b1, 1'b1, 256, 256, 256, -256);
        idle(2);
        chk_acc("conj", 0, 512);

        // Round half up: +128 -> 1, -128 -> 0, -129 -> -1
        step(1'b1, 1'b1, 1'b0, 1, 0, 128, 0);
        step(1'b1, 1'b0, 1'b0, -1, 0, 128, 0);
        step(1'b1, 1'b0, 1'b0, -1, 0, 129, 0);
        chk("rnd1", bus.acc_re, 1);
        idle(1);
        chk("rnd2", bus.acc_re, 1);
        idle(1);
        chk("rnd3", bus.acc_re, 0);

        // Frame of 32 samples of T=256, then one more to show the wrap
        for (int s = 1; s <= 35; s++) begin
            step(s <= 33, s == 1, 1'b0, 256, 0, 256, 0);
            chk($sformatf("frame.last%0d", s), bus.out_last, (s == 34));
            if (s == 34) chk("frame.sum32", bus.acc_re, 8192);
            if (s == 35) chk("frame.sum33", bus.acc_re, 8448);
        end

        // Max operands with sload every sample: no clamp
        for (int s = 1; s <= 5; s++) begin
            step(s <= 3, 1'b1, 1'b0, 32767, 0, 32767, 0);
            if (s >= 3) begin
                chk($sformatf("satld%0d", s), bus.acc_re, 4194048);
                chk($sformatf("satld.ovf%0d", s), bus.ovf, 0);
            end
        end

        // Accumulate max operands until acc_re clamps; ovf sticky
        for (int s = 1; s <= 6; s++) begin
            step(s <= 4, s == 1, 1'b0, 32767, 0, 32767, 0);
            if (s >= 3) begin
                chk($sformatf("satacc%0d", s), bus.acc_re, sat_exp[s-3]);
                chk($sformatf("satacc.ovf%0d", s), bus.ovf, ovf_exp[s-3]);
            end
        end
        idle(2);
        chk("sticky.ovf", bus.ovf, 1);
        chk("sticky.re", bus.acc_re, 8388607);
        step(1'b1, 1'b1, 1'b0, 256, 0, 256, 0);
        idle(2);
        chk("reload.re", bus.acc_re, 256);
        chk("reload.ovf", bus.ovf, 0);

        // Mixed samples back to back, then with gaps of 1..3 idle cycles
        for (int k = 0; k < 4; k++) step(1'b1, k == 0, scj[k], sar[k], sai[k], sbr[k], sbi[k]);
        idle(2);
        chk_acc("b2b", 256, 256);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, k == 0, scj[k], sar[k], sai[k], sbr[k], sbi[k]);
            if (k < 3) idle(gap[k]);
        end
        idle(2);
        chk_acc("gaps", 256, 256);

        // aclr with samples in flight
        step(1'b1, 1'b1, 1'b0, 256, 0, 256, 0);
        step(1'b1, 1'b0, 1'b0, 256, 0, 256, 0);
        bus.in_valid = 1'b1;
        #2;
        aclr = 1'b1;
        #1;
        chk_acc("aclr", 0, 0);
        chk("aclr.out_valid", bus.out_valid, 0);
        chk("aclr.ovf", bus.ovf, 0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        aclr = 1'b0;
        hist = '0;
        idle(4);
        chk_acc("post_aclr", 0, 0);
        step(1'b1, 1'b0, 1'b0, 256, 0, 256, 0);
        idle(2);
        chk_acc("first_after_aclr", 256, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
